// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command-frame controller.
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        S_H0   = 3'd0,
        S_H1   = 3'd1,
        S_CMD  = 3'd2,
        S_ADDR = 3'd3,
        S_DH   = 3'd4,
        S_DL   = 3'd5,
        S_CHK  = 3'd6,
        S_REQ  = 3'd7
    } state_t;

    localparam logic [7:0] CMD_WR = 8'h01;
    localparam logic [7:0] CMD_RD = 8'h02;

    localparam logic [1:0] ERR_CMD = 2'd1;
    localparam logic [1:0] ERR_CHK = 2'd2;
    localparam logic [1:0] ERR_TMO = 2'd3;

    localparam int FRAME_LEN = 7;

    function automatic logic is_valid_cmd(input logic [7:0] cmd);
        return (cmd == CMD_WR) || (cmd == CMD_RD);
    endfunction

endpackage

// File: rtl/uart_byte_timer.sv
// Inter-byte watchdog: down-counter reloaded on clear, expire on terminal count.
module uart_byte_timer #(
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic clk_i,
    input  logic rst_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);
    import uart_cmd_pkg::*;

    localparam logic [15:0] RELOAD = 16'(TIMEOUT_CYC - 1);

    logic [15:0] cnt_q;

    // Reload on clear, count down while enabled, park at zero.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= RELOAD;
        end else if (clear_i) begin
            cnt_q <= RELOAD;
        end else if (enable_i && (cnt_q != 16'd0)) begin
            cnt_q <= cnt_q - 16'd1;
        end
    end

    // A byte on the terminal cycle clears the timer and suppresses expiry.
    assign expire_o = enable_i & ~clear_i & (cnt_q == 16'd0);

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Assembles 7-byte UART command frames and issues one register access per frame.
//
// state  | meaning
// S_H0   | idle, hunting for HDR0
// S_H1   | HDR0 seen, expecting HDR1 (HDR0 again resyncs)
// S_CMD  | expecting command byte
// S_ADDR | expecting address byte
// S_DH   | expecting data high byte
// S_DL   | expecting data low byte
// S_CHK  | expecting checksum byte
// S_REQ  | register request outstanding, waiting for ack
module uart_cmd_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 50000,
    parameter logic [7:0]  HDR0        = 8'h55,
    parameter logic [7:0]  HDR1        = 8'hAA
) (
    input  logic        clk_i,
    input  logic        rst_n,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_done_i,
    input  logic        rx_error_i,
    input  logic        reg_ack_i,
    input  logic [15:0] reg_rdata_i,
    output logic        reg_wr_o,
    output logic        reg_rd_o,
    output logic [7:0]  reg_addr_o,
    output logic [15:0] reg_wdata_o,
    output logic [15:0] rd_data_o,
    output logic        rd_valid_o,
    output logic        frame_err_o,
    output logic [1:0]  err_code_o,
    output logic        busy_o
);
    import uart_cmd_pkg::*;

    state_t      state_q;
    logic [7:0]  cmd_q, addr_q, dh_q, dl_q, xor_q;
    logic        reg_wr_q, reg_rd_q, rd_valid_q, frame_err_q;
    logic [7:0]  reg_addr_q;
    logic [15:0] reg_wdata_q, rd_data_q;
    logic [1:0]  err_code_q;

    logic byte_v, in_frame, tmr_clear, tmr_expire;

    // A byte flagged with a receiver error is never used.
    assign byte_v    = rx_done_i & ~rx_error_i;
    assign in_frame  = (state_q != S_H0) && (state_q != S_REQ);
    assign tmr_clear = rx_done_i | ~in_frame;

    uart_byte_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
        .clk_i    (clk_i),
        .rst_n    (rst_n),
        .clear_i  (tmr_clear),
        .enable_i (in_frame),
        .expire_o (tmr_expire)
    );

    // Frame FSM with registered request, read-data and error outputs.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_H0;
            cmd_q       <= '0;
            addr_q      <= '0;
            dh_q        <= '0;
            dl_q        <= '0;
            xor_q       <= '0;
            reg_wr_q    <= 1'b0;
            reg_rd_q    <= 1'b0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            err_code_q  <= '0;
        end else begin
            rd_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            case (state_q)
                S_H0: begin
                    if (byte_v && (rx_data_i == HDR0)) state_q <= S_H1;
                end
                S_REQ: begin
                    if (reg_ack_i) begin
                        reg_wr_q <= 1'b0;
                        reg_rd_q <= 1'b0;
                        state_q  <= S_H0;
                        if (reg_rd_q) begin
                            rd_data_q  <= reg_rdata_i;
                            rd_valid_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    if (rx_error_i || tmr_expire) begin
                        state_q     <= S_H0;
                        frame_err_q <= 1'b1;
                        err_code_q  <= ERR_TMO;
                    end else if (byte_v) begin
                        case (state_q)
                            S_H1: begin
                                if (rx_data_i == HDR1) begin
                                    state_q <= S_CMD;
                                    xor_q   <= '0;
                                end else if (rx_data_i != HDR0) begin
                                    state_q <= S_H0;
                                end
                            end
                            S_CMD: begin
                                if (is_valid_cmd(rx_data_i)) begin
                                    cmd_q   <= rx_data_i;
                                    xor_q   <= xor_q ^ rx_data_i;
                                    state_q <= S_ADDR;
                                end else begin
                                    state_q     <= S_H0;
                                    frame_err_q <= 1'b1;
                                    err_code_q  <= ERR_CMD;
                                end
                            end
                            S_ADDR: begin
                                addr_q  <= rx_data_i;
                                xor_q   <= xor_q ^ rx_data_i;
                                state_q <= S_DH;
                            end
                            S_DH: begin
                                dh_q    <= rx_data_i;
                                xor_q   <= xor_q ^ rx_data_i;
                                state_q <= S_DL;
                            end
                            S_DL: begin
                                dl_q    <= rx_data_i;
                                xor_q   <= xor_q ^ rx_data_i;
                                state_q <= S_CHK;
                            end
                            S_CHK: begin
                                if (rx_data_i == xor_q) begin
                                    state_q    <= S_REQ;
                                    reg_addr_q <= addr_q;
                                    if (cmd_q == CMD_WR) begin
                                        reg_wr_q    <= 1'b1;
                                        reg_wdata_q <= {dh_q, dl_q};
                                    end else begin
                                        reg_rd_q <= 1'b1;
                                    end
                                end else begin
                                    state_q     <= S_H0;
                                    frame_err_q <= 1'b1;
                                    err_code_q  <= ERR_CHK;
                                end
                            end
                            default: state_q <= S_H0;
                        endcase
                    end
                end
            endcase
        end
    end

    assign reg_wr_o    = reg_wr_q;
    assign reg_rd_o    = reg_rd_q;
    assign reg_addr_o  = reg_addr_q;
    assign reg_wdata_o = reg_wdata_q;
    assign rd_data_o   = rd_data_q;
    assign rd_valid_o  = rd_valid_q;
    assign frame_err_o = frame_err_q;
    assign err_code_o  = err_code_q;
    assign busy_o      = (state_q != S_H0);

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Self-checking bench for uart_cmd_ctrl: scoreboard of expected output events.
module tb_uart_cmd_ctrl;

    localparam int TMO = 40;

    logic        clk_i = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data_i;
    logic        rx_done_i, rx_error_i, reg_ack_i;
    logic [15:0] reg_rdata_i;
    logic        reg_wr_o, reg_rd_o, rd_valid_o, frame_err_o, busy_o;
    logic [7:0]  reg_addr_o;
    logic [15:0] reg_wdata_o, rd_data_o;
    logic [1:0]  err_code_o;

    // kind: 0 write request, 1 read request, 2 frame error, 3 read data
    typedef struct {
        int          kind;
        logic [7:0]  addr;
        logic [15:0] data;
        logic [1:0]  code;
    } ev_t;

    ev_t exp_q[$];
    ev_t obs_q[$];
    int  errors = 0;
    int  checks = 0;
    logic wr_prev = 1'b0, rd_prev = 1'b0;

    always #5 clk_i = ~clk_i;

    uart_cmd_ctrl #(.TIMEOUT_CYC(TMO), .HDR0(8'h55), .HDR1(8'hAA)) dut (
        .clk_i(clk_i), .rst_n(rst_n),
        .rx_data_i(rx_data_i), .rx_done_i(rx_done_i), .rx_error_i(rx_error_i),
        .reg_ack_i(reg_ack_i), .reg_rdata_i(reg_rdata_i),
        .reg_wr_o(reg_wr_o), .reg_rd_o(reg_rd_o), .reg_addr_o(reg_addr_o),
        .reg_wdata_o(reg_wdata_o), .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o),
        .frame_err_o(frame_err_o), .err_code_o(err_code_o), .busy_o(busy_o)
    );

    // Output monitor, sampled on the falling edge.
    always @(negedge clk_i) begin
        if (frame_err_o) obs_q.push_back('{2, 8'h00, 16'h0000, err_code_o});
        if (rd_valid_o)  obs_q.push_back('{3, 8'h00, rd_data_o, 2'd0});
        if (reg_wr_o && !wr_prev) obs_q.push_back('{0, reg_addr_o, reg_wdata_o, 2'd0});
        if (reg_rd_o && !rd_prev) obs_q.push_back('{1, reg_addr_o, 16'h0000, 2'd0});
        wr_prev = reg_wr_o;
        rd_prev = reg_rd_o;
    end

    function automatic logic [7:0] cs(input logic [7:0] c, a, h, l);
        return c ^ a ^ h ^ l;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk_i);
        rx_data_i = b;
        rx_done_i = 1'b1;
        @(negedge clk_i);
        rx_done_i = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] c, a, h, l, k);
        logic [7:0] fr [7];
        fr = '{8'h55, 8'hAA, c, a, h, l, k};
        for (int i = 0; i < 7; i++) begin
            send_byte(fr[i]);
            idle(2);
        end
    endtask

    task automatic ack_now(input logic [15:0] rdata);
        @(negedge clk_i);
        reg_ack_i   = 1'b1;
        reg_rdata_i = rdata;
        @(negedge clk_i);
        reg_ack_i   = 1'b0;
        reg_rdata_i = 16'h0000;
    endtask

    // Pops the oldest expected and observed events, waiting a bounded time for the latter.
    task automatic pop_pair(output ev_t e, output ev_t o, output bit got);
        e   = exp_q.pop_front();
        got = 1'b0;
        o   = '{-1, 8'h00, 16'h0000, 2'd0};
        for (int i = 0; i < 300 && obs_q.size() == 0; i++) @(negedge clk_i);
        if (obs_q.size() != 0) begin
            o   = obs_q.pop_front();
            got = 1'b1;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; rx_data_i = '0; rx_done_i = 0; rx_error_i = 0;
        reg_ack_i = 0; reg_rdata_i = '0;
        idle(3);
        checks++;
        if ({reg_wr_o, reg_rd_o, rd_valid_o, frame_err_o, busy_o} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl got=%b want=00000",
                     {reg_wr_o, reg_rd_o, rd_valid_o, frame_err_o, busy_o});
        end
        checks++;
        if ({reg_addr_o, reg_wdata_o, rd_data_o, err_code_o} !== 42'b0) begin
            errors++;
            $display("FAIL reset_data got addr=%h wdata=%h rdata=%h code=%0d want all 0",
                     reg_addr_o, reg_wdata_o, rd_data_o, err_code_o);
        end
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_write;
        ev_t e, o; bit got;
        exp_q.push_back('{0, 8'h3C, 16'h1234, 2'd0});
        send_frame(8'h01, 8'h3C, 8'h12, 8'h34, cs(8'h01, 8'h3C, 8'h12, 8'h34));
        pop_pair(e, o, got);
        checks++;
        if (!got || o.kind != e.kind || o.addr !== e.addr || o.data !== e.data) begin
            errors++;
            $display("FAIL write_req got kind=%0d addr=%h data=%h want kind=%0d addr=%h data=%h",
                     o.kind, o.addr, o.data, e.kind, e.addr, e.data);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            checks++;
            if (reg_wr_o !== 1'b1 || reg_addr_o !== 8'h3C || reg_wdata_o !== 16'h1234) begin
                errors++;
                $display("FAIL write_hold cyc=%0d got wr=%b addr=%h wdata=%h want 1/3c/1234",
                         i, reg_wr_o, reg_addr_o, reg_wdata_o);
            end
        end
        ack_now(16'h0000);
        checks++;
        if (reg_wr_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL write_release got wr=%b busy=%b want 0/0", reg_wr_o, busy_o);
        end
        idle(2);
    endtask

    task automatic test_read;
        ev_t e, o; bit got;
        exp_q.push_back('{1, 8'h10, 16'h0000, 2'd0});
        exp_q.push_back('{3, 8'h00, 16'hBEEF, 2'd0});
        send_frame(8'h02, 8'h10, 8'h00, 8'h00, cs(8'h02, 8'h10, 8'h00, 8'h00));
        pop_pair(e, o, got);
        checks++;
        if (!got || o.kind != e.kind || o.addr !== e.addr) begin
            errors++;
            $display("FAIL read_req got kind=%0d addr=%h want kind=%0d addr=%h",
                     o.kind, o.addr, e.kind, e.addr);
        end
        idle(3);
        checks++;
        if (reg_rd_o !== 1'b1 || reg_wr_o !== 1'b0) begin
            errors++;
            $display("FAIL read_hold got rd=%b wr=%b want 1/0", reg_rd_o, reg_wr_o);
        end
        ack_now(16'hBEEF);
        checks++;
        if (reg_rd_o !== 1'b0 || rd_valid_o !== 1'b1 || rd_data_o !== 16'hBEEF) begin
            errors++;
            $display("FAIL read_data got rd=%b valid=%b data=%h want 0/1/beef",
                     reg_rd_o, rd_valid_o, rd_data_o);
        end
        @(negedge clk_i);
        checks++;
        if (rd_valid_o !== 1'b0 || rd_data_o !== 16'hBEEF) begin
            errors++;
            $display("FAIL read_pulse got valid=%b data=%h want 0/beef", rd_valid_o, rd_data_o);
        end
        pop_pair(e, o, got);
        checks++;
        if (!got || o.kind != e.kind || o.data !== e.data) begin
            errors++;
            $display("FAIL read_event got kind=%0d data=%h want kind=%0d data=%h",
                     o.kind, o.data, e.kind, e.data);
        end
        idle(2);
    endtask

    task automatic test_bad_checksum;
        ev_t e, o; bit got;
        exp_q.push_back('{2, 8'h00, 16'h0000, 2'd2});
        send_frame(8'h01, 8'h3C, 8'h12, 8'h34, 8'h0D);
        pop_pair(e, o, got);
        checks++;
        if (!got || o.kind != e.kind || o.code !== e.code || reg_wr_o !== 1'b0) begin
            errors++;
            $display("FAIL bad_chk got kind=%0d code=%0d wr=%b want kind=2 code=2 wr=0",
                     o.kind, o.code, reg_wr_o);
        end
        exp_q.push_back('{0, 8'h5A, 16'hA55A, 2'd0});
        send_frame(8'h01, 8'h5A, 8'hA5, 8'h5A, cs(8'h01, 8'h5A, 8'hA5, 8'h5A));
        pop_pair(e, o, got);
        checks++;
        if (!got || o.kind != e.kind || o.addr !== e.addr || o.data !== e.data) begin
            errors++;
            $display("FAIL after_bad got kind=%0d addr=%h data=%h want kind=0 addr=%h data=%h",
                     o.kind, o.addr, o.data, e.addr, e.data);
        end
        ack_now(16'h0000);
        idle(2);
    endtask

    task automatic test_resync;
        ev_t e, o; bit got;
        logic [7:0] seq [5];
        seq = '{8'h00, 8'h55, 8'h55, 8'hAA, 8'h03};
        exp_q.push_back('{2, 8'h00, 16'h0000, 2'd1});
        for (int i = 0; i < 5; i++) begin
            send_byte(seq[i]);
            idle(1);
        end
        pop_pair(e, o, got);
        checks++;
        if (!got || o.kind != e.kind || o.code !== e.code) begin
            errors++;
            $display("FAIL resync_cmd got kind=%0d code=%0d want kind=2 code=1", o.kind, o.code);
        end
        idle(2);
    endtask

    task automatic test_timeout;
        ev_t e, o; bit got;
        bit early;
        early = 1'b0;
        send_byte(8'h55); idle(2);
        send_byte(8'hAA); idle(2);
        send_byte(8'h01);
        // The CMD byte reloads the timer; the abort lands TMO cycles after it.
        for (int j = 1; j < TMO; j++) begin
            @(negedge clk_i);
            if (frame_err_o) early = 1'b1;
        end
        @(negedge clk_i);
        checks++;
        if (early || frame_err_o !== 1'b1 || err_code_o !== 2'd3 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL timeout_edge got early=%b err=%b code=%0d busy=%b want 0/1/3/0",
                     early, frame_err_o, err_code_o, busy_o);
        end
        exp_q.push_back('{2, 8'h00, 16'h0000, 2'd3});
        pop_pair(e, o, got);
        checks++;
        if (!got || o.kind != e.kind || o.code !== e.code) begin
            errors++;
            $display("FAIL timeout_event got kind=%0d code=%0d want kind=2 code=3", o.kind, o.code);
        end
        idle(2);
        // Byte lands exactly on the terminal cycle: must be accepted.
        exp_q.push_back('{0, 8'h3C, 16'h1234, 2'd0});
        send_byte(8'h55); idle(2);
        send_byte(8'hAA); idle(2);
        send_byte(8'h01);
        idle(TMO - 2);
        send_byte(8'h3C); idle(2);
        send_byte(8'h12); idle(2);
        send_byte(8'h34); idle(2);
        send_byte(cs(8'h01, 8'h3C, 8'h12, 8'h34)); idle(2);
        pop_pair(e, o, got);
        checks++;
        if (!got || o.kind != e.kind || o.addr !== e.addr || o.data !== e.data) begin
            errors++;
            $display("FAIL timeout_byte_wins got kind=%0d addr=%h data=%h want kind=0 addr=3c data=1234",
                     o.kind, o.addr, o.data);
        end
        ack_now(16'h0000);
        idle(2);
    endtask

    task automatic test_line_err_and_reset;
        ev_t e, o; bit got;
        send_byte(8'h55); idle(2);
        send_byte(8'hAA); idle(2);
        send_byte(8'h01); idle(2);
        send_byte(8'h3C); idle(2);
        @(negedge clk_i);
        rx_data_i = 8'h12; rx_done_i = 1'b1; rx_error_i = 1'b1;
        @(negedge clk_i);
        rx_done_i = 1'b0; rx_error_i = 1'b0;
        exp_q.push_back('{2, 8'h00, 16'h0000, 2'd3});
        pop_pair(e, o, got);
        checks++;
        if (!got || o.kind != e.kind || o.code !== e.code) begin
            errors++;
            $display("FAIL line_err got kind=%0d code=%0d want kind=2 code=3", o.kind, o.code);
        end
        idle(2);
        exp_q.push_back('{0, 8'h77, 16'h0102, 2'd0});
        send_frame(8'h01, 8'h77, 8'h01, 8'h02, cs(8'h01, 8'h77, 8'h01, 8'h02));
        pop_pair(e, o, got);
        checks++;
        if (!got || o.kind != e.kind || o.addr !== e.addr || o.data !== e.data) begin
            errors++;
            $display("FAIL pre_reset_req got kind=%0d addr=%h data=%h want kind=0 addr=77 data=0102",
                     o.kind, o.addr, o.data);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (reg_wr_o !== 1'b0 || busy_o !== 1'b0 || reg_addr_o !== 8'h00) begin
            errors++;
            $display("FAIL reset_in_req got wr=%b busy=%b addr=%h want 0/0/00",
                     reg_wr_o, busy_o, reg_addr_o);
        end
        @(negedge clk_i);
        rst_n = 1'b1;
        idle(4);
        checks++;
        if (reg_wr_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL after_reset got wr=%b busy=%b want 0/0", reg_wr_o, busy_o);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_bad_checksum();
        test_resync();
        test_timeout();
        test_line_err_and_reset();
        idle(2);
        checks++;
        if (obs_q.size() != 0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got obs=%0d exp=%0d left want 0/0",
                     obs_q.size(), exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
